// File: rtl/des_key_schedule_rev.sv
// Sequential DES subkey generator: loads a key through PC-1 and emits one PC-2 subkey
// per valid/ready transfer, K16..K1 (right rotations) or K1..K16 (left rotations).
module des_key_schedule_rev #(
   parameter bit DECRYPT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:64] key_in,
   output logic        busy,
   output logic [1:48] subkey,
   output logic        key_valid,
   input  logic        key_ready,
   output logic [1:4]  round_idx,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

   state_t      state_q, state_d;
   logic [1:28] c_q, c_d, d_q, d_d;
   logic [1:48] subkey_q, subkey_d;
   logic        key_valid_q, key_valid_d;
   logic [1:4]  round_idx_q, round_idx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [1:56] cd_ld;
   logic [1:4]  r_nxt;
   logic        two_nxt;
   logic        unused_parity;

   function automatic logic [1:56] pc1(input logic [1:64] k);
      return {k[57], k[49], k[41], k[33], k[25], k[17], k[9],  k[1],
              k[58], k[50], k[42], k[34], k[26], k[18], k[10], k[2],
              k[59], k[51], k[43], k[35], k[27], k[19], k[11], k[3],
              k[60], k[52], k[44], k[36],
              k[63], k[55], k[47], k[39], k[31], k[23], k[15], k[7],
              k[62], k[54], k[46], k[38], k[30], k[22], k[14], k[6],
              k[61], k[53], k[45], k[37], k[29], k[21], k[13], k[5],
              k[28], k[20], k[12], k[4]};
   endfunction

   function automatic logic [1:48] pc2(input logic [1:56] cd);
      return {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],  cd[3],  cd[28],
              cd[15], cd[6],  cd[21], cd[10], cd[23], cd[19], cd[12], cd[4],
              cd[26], cd[8],  cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
              cd[41], cd[52], cd[31], cd[37], cd[47], cd[55], cd[30], cd[40],
              cd[51], cd[45], cd[33], cd[48], cd[44], cd[49], cd[39], cd[56],
              cd[34], cd[53], cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
   endfunction

   // Direction is fixed at elaboration; two selects a shift of 2 instead of 1.
   function automatic logic [1:28] rot(input logic [1:28] x, input logic two);
      if (DECRYPT) return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
      else         return two ? {x[3:28], x[1:2]}   : {x[2:28], x[1]};
   endfunction

   assign unused_parity = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                            key_in[40], key_in[48], key_in[56], key_in[64]};

   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      d_d         = d_q;
      subkey_d    = subkey_q;
      key_valid_d = key_valid_q;
      round_idx_d = round_idx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cd_ld       = pc1(key_in);
      r_nxt       = round_idx_q + 4'd1;
      // Rounds 2, 9 and 16 (16 wraps to 0) shift by one, all others by two.
      two_nxt     = !(r_nxt == 4'd2 || r_nxt == 4'd9 || r_nxt == 4'd0);
      case (state_q)
         IDLE: begin
            if (start) begin
               // Decrypt starts at C0/D0 since the full encrypt rotation is 28.
               c_d         = DECRYPT ? cd_ld[1:28]  : rot(cd_ld[1:28], 1'b0);
               d_d         = DECRYPT ? cd_ld[29:56] : rot(cd_ld[29:56], 1'b0);
               subkey_d    = pc2({c_d, d_d});
               key_valid_d = 1'b1;
               round_idx_d = 4'd1;
               busy_d      = 1'b1;
               state_d     = EMIT;
            end
         end
         EMIT: begin
            if (key_valid_q && key_ready) begin
               if (round_idx_q == 4'd0) begin
                  key_valid_d = 1'b0;
                  subkey_d    = '0;
                  done_d      = 1'b1;
                  state_d     = FIN;
               end else begin
                  c_d         = rot(c_q, two_nxt);
                  d_d         = rot(d_q, two_nxt);
                  subkey_d    = pc2({c_d, d_d});
                  round_idx_d = r_nxt;
               end
            end
         end
         FIN: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         c_q         <= '0;
         d_q         <= '0;
         subkey_q    <= '0;
         key_valid_q <= 1'b0;
         round_idx_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         d_q         <= d_d;
         subkey_q    <= subkey_d;
         key_valid_q <= key_valid_d;
         round_idx_q <= round_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign subkey    = subkey_q;
   assign key_valid = key_valid_q;
   assign round_idx = round_idx_q;
   assign done      = done_q;

endmodule

// File: tb/tb_des_key_schedule_rev.sv
// Bench for des_key_schedule_rev: decrypt and forward instances run side by side
// against the published example subkeys and a table-based key schedule model.
module tb_des_key_schedule_rev;

   logic        clk = 1'b0;
   logic        rst, start, key_ready;
   logic [1:64] key_in;
   logic        busy_d1, vld_d1, done_d1, busy_f, vld_f, done_f;
   logic [1:48] sk_d1, sk_f;
   logic [1:4]  ri_d1, ri_f;

   int pass_cnt = 0;
   int total_cnt = 0;

   localparam logic [1:64] KEY = 64'h133457799BBCDFF1;

   always #5 clk = ~clk;

   des_key_schedule_rev #(.DECRYPT(1'b1)) dut_dec (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy_d1),
      .subkey(sk_d1), .key_valid(vld_d1), .key_ready(key_ready),
      .round_idx(ri_d1), .done(done_d1));

   des_key_schedule_rev #(.DECRYPT(1'b0)) dut_fwd (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy_f),
      .subkey(sk_f), .key_valid(vld_f), .key_ready(key_ready),
      .round_idx(ri_f), .done(done_f));

   int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                    60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                    29,21,13,5,28,20,12,4};
   int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
   int SH  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   logic [47:0] mk [1:16];

   // Encryption-order schedule K1..K16 straight from the standard tables.
   task automatic model(input logic [1:64] k);
      logic [1:28] c, d;
      logic [1:56] cd;
      for (int j = 0; j < 28; j++) begin
         c[j+1] = k[PC1[j]];
         d[j+1] = k[PC1[j+28]];
      end
      for (int r = 1; r <= 16; r++) begin
         for (int s = 0; s < SH[r-1]; s++) begin
            c = {c[2:28], c[1]};
            d = {d[2:28], d[1]};
         end
         cd = {c, d};
         for (int j = 0; j < 48; j++) mk[r][47-j] = cd[PC2[j]];
      end
   endtask

   typedef struct {
      int          stalls;
      logic [3:0]  ridx;
      logic [47:0] dec_k;
      logic [47:0] fwd_k;
   } vec_t;

   vec_t        tbl [16];
   logic [47:0] known [1:16];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_idle(input string name);
      chk({name, "_subkey"}, {sk_d1, sk_f}, 96'h0);
      chk({name, "_flags"}, {vld_d1, busy_d1, done_d1, vld_f, busy_f, done_f}, 6'b0);
      chk({name, "_ridx"}, {ri_d1, ri_f}, 8'h0);
   endtask

   task automatic check_done(input string name);
      chk({name, "_done"}, {done_d1, done_f}, 2'b11);
      chk({name, "_valid"}, {vld_d1, vld_f}, 2'b00);
      chk({name, "_subkey"}, {sk_d1, sk_f}, 96'h0);
   endtask

   task automatic check_vec(input int i, input string name);
      chk($sformatf("%s_dec_r%0d", name, i+1), sk_d1, tbl[i].dec_k);
      chk($sformatf("%s_fwd_r%0d", name, i+1), sk_f, tbl[i].fwd_k);
      chk($sformatf("%s_ridx_r%0d", name, i+1), {ri_d1, ri_f}, {tbl[i].ridx, tbl[i].ridx});
      chk($sformatf("%s_vb_r%0d", name, i+1), {vld_d1, busy_d1, vld_f, busy_f}, 4'b1111);
   endtask

   // Walks all 16 table rounds; optionally pulses start with a new key or asserts reset.
   task automatic walk_tbl(input int inj_at, input int rst_at);
      for (int i = 0; i < 16; i++) begin
         key_ready = 1'b0;
         for (int s = 0; s < tbl[i].stalls; s++) begin
            check_vec(i, "hold");
            step();
         end
         check_vec(i, "vec");
         if (i == inj_at) begin
            start  = 1'b1;
            key_in = 64'hFFFF_0000_A5A5_5A5A;
         end
         key_ready = 1'b1;
         if (i == rst_at) rst = 1'b1;
         step();
         start = 1'b0;
         if (i == rst_at) begin
            rst = 1'b0;
            key_ready = 1'b0;
            return;
         end
      end
      key_ready = 1'b0;
   endtask

   task automatic run_rand(input logic [1:64] k, input int stall_pct);
      int n, bad, cyc;
      model(k);
      key_in = k;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0; bad = 0; cyc = 0;
      while (n < 16 && cyc < 400) begin
         key_ready = ($urandom_range(99) >= stall_pct);
         if (vld_d1 && key_ready) begin
            if (sk_d1 !== mk[16-n] || sk_f !== mk[n+1] || !vld_f ||
                ri_d1 !== 4'(n+1) || ri_f !== 4'(n+1)) bad++;
            n++;
         end
         step();
         cyc++;
      end
      key_ready = 1'b0;
      chk("rand_subkeys", bad, 0);
      chk("rand_transfers", n, 16);
      chk("rand_done", {done_d1, done_f}, 2'b11);
      step();
      chk("rand_done_once", {done_d1, done_f, busy_d1, busy_f}, 4'b0);
   endtask

   initial begin
      known[1]  = 48'h1B02EFFC7072; known[2]  = 48'h79AED9DBC9E5;
      known[3]  = 48'h55FC8A42CF99; known[4]  = 48'h72ADD6DB351D;
      known[5]  = 48'h7CEC07EB53A8; known[6]  = 48'h63A53E507B2F;
      known[7]  = 48'hEC84B7F618BC; known[8]  = 48'hF78A3AC13BFB;
      known[9]  = 48'hE0DBEBEDE781; known[10] = 48'hB1F347BA464F;
      known[11] = 48'h215FD3DED386; known[12] = 48'h7571F59467E9;
      known[13] = 48'h97C5D1FABA41; known[14] = 48'h5F43B7F2E73A;
      known[15] = 48'hBF918D3D3F0A; known[16] = 48'hCB3D8B0E17F5;
      for (int i = 0; i < 16; i++) begin
         tbl[i].stalls = (i == 2) ? 5 : ((i == 10) ? 1 : 0);
         tbl[i].ridx   = 4'(i + 1);
         tbl[i].dec_k  = known[16-i];
         tbl[i].fwd_k  = known[i+1];
      end

      rst = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = '0;
      step();
      step();
      check_idle("reset");
      rst = 1'b0;
      step();

      // Full sequence with stalls at round 3 and round 11.
      key_in = KEY;
      start = 1'b1;
      step();
      start = 1'b0;
      walk_tbl(-1, -1);
      check_done("done1");

      // Start during FIN is ignored; held start is taken the cycle after.
      start = 1'b1;
      step();
      check_idle("fin_start_ignored");
      step();
      start = 1'b0;
      walk_tbl(6, -1);
      check_done("done2");
      step();
      check_idle("after_done2");

      // Reset while round 9 is presented.
      key_in = KEY;
      start = 1'b1;
      step();
      start = 1'b0;
      walk_tbl(-1, 8);
      check_idle("mid_reset");
      step();
      check_idle("mid_reset_idle");

      run_rand(KEY, 0);
      for (int t = 0; t < 200; t++) begin
         logic [1:64] rk;
         rk = {$urandom(), $urandom()};
         run_rand(rk, 30);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
